// File: rtl/indirect_engine.sv
// Purpose : resolves up to MAX_LEVELS pointer indirections before the final memory access.
// Latency : p_levels=0 is a combinational pass-through; otherwise 1 latch cycle + levels pointer reads + 1 final access.
// Backpr. : every memory access is held stable until d_resp; the pipeline request is held until p_resp.
// Ports   : clk/reset_n (sync, active-low); p_* pipeline request/response; busy;
//           d_* memory request (read/write/address/wdata/byte_enable) and response (d_resp/d_rdata).
module indirect_engine #(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 16,
  parameter int MAX_LEVELS = 2,
  localparam int MASK_W    = DATA_W / 8,
  localparam int LVL_W     = $clog2(MAX_LEVELS + 1)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              p_read,
  input  logic              p_write,
  input  logic [ADDR_W-1:0] p_address,
  input  logic [DATA_W-1:0] p_wdata,
  input  logic [MASK_W-1:0] p_byte_enable,
  input  logic [LVL_W-1:0]  p_levels,
  output logic              p_resp,
  output logic [DATA_W-1:0] p_rdata,
  output logic              busy,
  output logic              d_read,
  output logic              d_write,
  output logic [ADDR_W-1:0] d_address,
  output logic [DATA_W-1:0] d_wdata,
  output logic [MASK_W-1:0] d_byte_enable,
  input  logic              d_resp,
  input  logic [DATA_W-1:0] d_rdata
);

  typedef enum logic [1:0] {IDLE, PTR, FINAL} state_t;

  localparam logic [LVL_W-1:0] MAX_LVL = LVL_W'(MAX_LEVELS);
  localparam logic [LVL_W-1:0] ONE_LVL = LVL_W'(1);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] addr_reg;
  logic [DATA_W-1:0] wdata_reg;
  logic [MASK_W-1:0] mask_reg;
  logic              op_write;  // 1 = final access is a write
  logic [LVL_W-1:0]  cnt;       // pointer reads still outstanding
  logic              latch_req;

  always_comb begin
    state_nxt     = state;
    latch_req     = 1'b0;
    d_read        = 1'b0;
    d_write       = 1'b0;
    d_address     = addr_reg;
    d_wdata       = wdata_reg;
    d_byte_enable = mask_reg;
    p_resp        = 1'b0;
    p_rdata       = d_rdata;
    case (state)
      IDLE: begin
        if (p_levels == '0) begin
          // Direct access: a simultaneous read+write degrades to a read.
          d_read        = p_read;
          d_write       = p_write & ~p_read;
          d_address     = p_address;
          d_wdata       = p_wdata;
          d_byte_enable = p_byte_enable;
          p_resp        = d_resp & (p_read | p_write);
        end else if (p_read || p_write) begin
          latch_req = 1'b1;
          state_nxt = PTR;
        end
      end
      PTR: begin
        d_read        = 1'b1;
        d_byte_enable = '1;
        if (d_resp) state_nxt = (cnt == ONE_LVL) ? FINAL : PTR;
      end
      FINAL: begin
        d_read  = ~op_write;
        d_write = op_write;
        p_resp  = d_resp;
        if (d_resp) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // Reset silences both sides immediately, so a stray d_resp cannot complete anything.
    if (!reset_n) begin
      d_read    = 1'b0;
      d_write   = 1'b0;
      p_resp    = 1'b0;
      state_nxt = IDLE;
    end
    busy = reset_n && (state != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      cnt       <= '0;
      addr_reg  <= '0;
      wdata_reg <= '0;
      mask_reg  <= '0;
      op_write  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (latch_req) begin
        addr_reg  <= p_address;
        wdata_reg <= p_wdata;
        mask_reg  <= p_byte_enable;
        op_write  <= p_write & ~p_read;
        cnt       <= (p_levels > MAX_LVL) ? MAX_LVL : p_levels;
      end
      if (state == PTR && d_resp) begin
        // Pointer words are used verbatim as the next address.
        addr_reg <= d_rdata[ADDR_W-1:0];
        cnt      <= cnt - ONE_LVL;
      end
    end
  end

endmodule

// File: tb/tb_indirect_engine.sv
module tb_indirect_engine;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        p_read, p_write;
  logic [15:0] p_address, p_wdata;
  logic [1:0]  p_byte_enable;
  logic [1:0]  p_levels;
  logic        p_resp;
  logic [15:0] p_rdata;
  logic        busy;
  logic        d_read, d_write;
  logic [15:0] d_address, d_wdata;
  logic [1:0]  d_byte_enable;
  logic        d_resp;
  logic [15:0] d_rdata;

  int tests_run = 0;
  int fails     = 0;

  indirect_engine #(.DATA_W(16), .ADDR_W(16), .MAX_LEVELS(2)) dut (
    .clk(clk), .reset_n(reset_n),
    .p_read(p_read), .p_write(p_write), .p_address(p_address), .p_wdata(p_wdata),
    .p_byte_enable(p_byte_enable), .p_levels(p_levels),
    .p_resp(p_resp), .p_rdata(p_rdata), .busy(busy),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
    .d_byte_enable(d_byte_enable), .d_resp(d_resp), .d_rdata(d_rdata)
  );

  always #5 clk = ~clk;

  // Memory model with a programmable number of wait cycles per access.
  logic [15:0] mem [0:2047];
  int          wait_cycles = 0;
  int          wcnt = 0;
  logic        mem_en = 1'b1;

  assign d_resp  = mem_en && (d_read || d_write) && (wcnt == wait_cycles);
  assign d_rdata = mem[d_address[10:0]];

  typedef struct {
    logic [15:0] addr;
    logic        rd;
    logic        wr;
    logic [1:0]  be;
    logic [15:0] wdata;
    logic        presp;
  } txn_t;

  txn_t        log_q[$];
  int          presp_cnt = 0;
  int          unstable  = 0;
  logic        pend = 1'b0;
  logic [35:0] snap;

  always @(posedge clk) begin
    if (pend && (d_read || d_write) &&
        ({d_read, d_write, d_address, d_wdata, d_byte_enable} !== snap))
      unstable++;
    if ((d_read || d_write) && !d_resp) begin
      pend = 1'b1;
      snap = {d_read, d_write, d_address, d_wdata, d_byte_enable};
    end else begin
      pend = 1'b0;
    end
    if ((d_read || d_write) && d_resp) begin
      log_q.push_back('{d_address, d_read, d_write, d_byte_enable, d_wdata, p_resp});
      if (d_write) begin
        if (d_byte_enable[0]) mem[d_address[10:0]][7:0]  <= d_wdata[7:0];
        if (d_byte_enable[1]) mem[d_address[10:0]][15:8] <= d_wdata[15:8];
      end
    end
    if (p_resp) presp_cnt++;
    if (!(d_read || d_write) || d_resp) wcnt <= 0;
    else wcnt <= wcnt + 1;
  end

  // Issues one pipeline request and holds it until p_resp; lat = cycles occupied, -1 on timeout.
  task automatic run_req(input logic [15:0] addr, input logic rd, input logic wr,
                         input logic [15:0] wd, input logic [1:0] be, input logic [1:0] lv,
                         input int chg_at, input logic [15:0] alt,
                         output int lat, output logic [15:0] rdata);
    lat   = -1;
    rdata = 16'h0;
    @(negedge clk);
    p_address = addr; p_read = rd; p_write = wr;
    p_wdata = wd; p_byte_enable = be; p_levels = lv;
    for (int c = 0; c < 60; c++) begin
      #1;
      if (p_resp) begin
        rdata = p_rdata;
        lat   = c + 1;
        break;
      end
      @(negedge clk);
      if (c + 1 == chg_at) p_address = alt;
    end
    @(negedge clk);
    p_read = 1'b0; p_write = 1'b0; p_levels = 2'd0;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    p_read = 1'b1; p_write = 1'b0; p_address = 16'h0040;
    p_wdata = 16'h0; p_byte_enable = 2'b11; p_levels = 2'd0;
    repeat (2) @(negedge clk);
    #1;
    tests_run++; if (d_read !== 1'b0) begin fails++; $display("FAIL reset_d_read got=%b exp=0", d_read); end
    tests_run++; if (d_write !== 1'b0) begin fails++; $display("FAIL reset_d_write got=%b exp=0", d_write); end
    tests_run++; if (p_resp !== 1'b0) begin fails++; $display("FAIL reset_p_resp got=%b exp=0", p_resp); end
    tests_run++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got=%b exp=0", busy); end
    @(negedge clk);
    p_read = 1'b0;
    reset_n = 1'b1;
  endtask

  task automatic test_direct_read;
    @(negedge clk);
    p_read = 1'b1; p_address = 16'h0040; p_levels = 2'd0;
    #1;
    tests_run++; if (p_resp !== 1'b1) begin fails++; $display("FAIL direct_p_resp got=%b exp=1", p_resp); end
    tests_run++; if (p_rdata !== 16'hBEEF) begin fails++; $display("FAIL direct_rdata got=%h exp=beef", p_rdata); end
    tests_run++; if (busy !== 1'b0) begin fails++; $display("FAIL direct_busy got=%b exp=0", busy); end
    tests_run++; if (d_address !== 16'h0040) begin fails++; $display("FAIL direct_d_address got=%h exp=0040", d_address); end
    @(negedge clk);
    p_read = 1'b0;
  endtask

  task automatic test_ldi;
    int lat; logic [15:0] rd;
    log_q.delete();
    run_req(16'h0010, 1'b1, 1'b0, 16'h0, 2'b11, 2'd1, 0, 16'h0, lat, rd);
    tests_run++; if (lat !== 3) begin fails++; $display("FAIL ldi_latency got=%0d exp=3", lat); end
    tests_run++; if (rd !== 16'h1234) begin fails++; $display("FAIL ldi_rdata got=%h exp=1234", rd); end
    tests_run++; if (log_q.size() !== 2) begin fails++; $display("FAIL ldi_txn_count got=%0d exp=2", log_q.size()); end
    tests_run++; if (log_q[0].addr !== 16'h0010 || log_q[0].rd !== 1'b1 || log_q[0].presp !== 1'b0)
      begin fails++; $display("FAIL ldi_ptr_read got=%h/rd%b/resp%b exp=0010/rd1/resp0", log_q[0].addr, log_q[0].rd, log_q[0].presp); end
    tests_run++; if (log_q[1].addr !== 16'h0200 || log_q[1].rd !== 1'b1 || log_q[1].presp !== 1'b1)
      begin fails++; $display("FAIL ldi_final got=%h/rd%b/resp%b exp=0200/rd1/resp1", log_q[1].addr, log_q[1].rd, log_q[1].presp); end
  endtask

  task automatic test_sti;
    int lat; logic [15:0] rd;
    log_q.delete();
    run_req(16'h0020, 1'b0, 1'b1, 16'hA5A5, 2'b01, 2'd1, 0, 16'h0, lat, rd);
    tests_run++; if (lat !== 3) begin fails++; $display("FAIL sti_latency got=%0d exp=3", lat); end
    tests_run++; if (log_q[0].rd !== 1'b1 || log_q[0].wr !== 1'b0 || log_q[0].be !== 2'b11)
      begin fails++; $display("FAIL sti_ptr_read got=rd%b/wr%b/be%b exp=rd1/wr0/be11", log_q[0].rd, log_q[0].wr, log_q[0].be); end
    tests_run++; if (log_q[1].addr !== 16'h0300 || log_q[1].wr !== 1'b1 || log_q[1].rd !== 1'b0 ||
                     log_q[1].wdata !== 16'hA5A5 || log_q[1].be !== 2'b01)
      begin fails++; $display("FAIL sti_write got=%h/wr%b/rd%b/%h/be%b exp=0300/wr1/rd0/a5a5/be01",
                              log_q[1].addr, log_q[1].wr, log_q[1].rd, log_q[1].wdata, log_q[1].be); end
    tests_run++; if (mem[11'h300] !== 16'h11A5) begin fails++; $display("FAIL sti_mem got=%h exp=11a5", mem[11'h300]); end
  endtask

  task automatic test_rw_conflict;
    int lat; logic [15:0] rd;
    @(negedge clk);
    p_read = 1'b1; p_write = 1'b1; p_address = 16'h0041; p_levels = 2'd0;
    #1;
    tests_run++; if (d_write !== 1'b0 || d_read !== 1'b1)
      begin fails++; $display("FAIL conflict_direct got=rd%b/wr%b exp=rd1/wr0", d_read, d_write); end
    @(negedge clk);
    p_read = 1'b0; p_write = 1'b0;
    log_q.delete();
    run_req(16'h0022, 1'b1, 1'b1, 16'h9999, 2'b11, 2'd1, 0, 16'h0, lat, rd);
    tests_run++; if (log_q[1].wr !== 1'b0 || rd !== 16'h5555)
      begin fails++; $display("FAIL conflict_indirect got=wr%b/%h exp=wr0/5555", log_q[1].wr, rd); end
    tests_run++; if (mem[11'h301] !== 16'h5555) begin fails++; $display("FAIL conflict_mem got=%h exp=5555", mem[11'h301]); end
  endtask

  task automatic test_chain_waits;
    int lat; logic [15:0] rd; int pc0;
    log_q.delete();
    wait_cycles = 3;
    unstable = 0;
    pc0 = presp_cnt;
    run_req(16'h0002, 1'b1, 1'b0, 16'h0, 2'b11, 2'd2, 3, 16'h0050, lat, rd);
    wait_cycles = 0;
    tests_run++; if (lat !== 13) begin fails++; $display("FAIL chain_latency got=%0d exp=13", lat); end
    tests_run++; if (rd !== 16'h00FF) begin fails++; $display("FAIL chain_rdata got=%h exp=00ff", rd); end
    tests_run++; if (unstable !== 0) begin fails++; $display("FAIL chain_stable got=%0d exp=0", unstable); end
    tests_run++; if (presp_cnt - pc0 !== 1) begin fails++; $display("FAIL chain_resp_count got=%0d exp=1", presp_cnt - pc0); end
    tests_run++; if (log_q.size() !== 3 || log_q[0].addr !== 16'h0002 || log_q[1].addr !== 16'h0100 || log_q[2].addr !== 16'h0400)
      begin fails++; $display("FAIL chain_addrs got=%0d:%h,%h,%h exp=3:0002,0100,0400",
                              log_q.size(), log_q[0].addr, log_q[1].addr, log_q[2].addr); end
  endtask

  task automatic test_clamp;
    int lat; logic [15:0] rd;
    log_q.delete();
    // 3 is the largest encodable level count and exceeds MAX_LEVELS=2.
    run_req(16'h0030, 1'b1, 1'b0, 16'h0, 2'b11, 2'd3, 0, 16'h0, lat, rd);
    tests_run++; if (log_q.size() !== 3) begin fails++; $display("FAIL clamp_txn_count got=%0d exp=3", log_q.size()); end
    tests_run++; if (rd !== 16'h0077 || lat !== 4) begin fails++; $display("FAIL clamp_result got=%h/%0d exp=0077/4", rd, lat); end
  endtask

  task automatic test_reset_midop;
    int pc0;
    pc0 = presp_cnt;
    mem_en = 1'b0;
    @(negedge clk);
    p_read = 1'b1; p_address = 16'h0010; p_levels = 2'd1;
    @(negedge clk);
    #1;
    tests_run++; if (busy !== 1'b1 || d_read !== 1'b1 || d_address !== 16'h0010)
      begin fails++; $display("FAIL midop_ptr got=busy%b/rd%b/%h exp=busy1/rd1/0010", busy, d_read, d_address); end
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    tests_run++; if (d_read !== 1'b0 || d_write !== 1'b0 || p_resp !== 1'b0 || busy !== 1'b0)
      begin fails++; $display("FAIL midop_reset got=rd%b/wr%b/resp%b/busy%b exp=0/0/0/0", d_read, d_write, p_resp, busy); end
    @(negedge clk);
    p_read = 1'b0; p_levels = 2'd0;
    mem_en = 1'b1;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    #1;
    tests_run++; if (busy !== 1'b0 || d_read !== 1'b0)
      begin fails++; $display("FAIL midop_after got=busy%b/rd%b exp=busy0/rd0", busy, d_read); end
    tests_run++; if (presp_cnt !== pc0) begin fails++; $display("FAIL midop_no_resp got=%0d exp=%0d", presp_cnt, pc0); end
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = 16'h0000;
    mem[11'h040] = 16'hBEEF;
    mem[11'h010] = 16'h0200; mem[11'h200] = 16'h1234;
    mem[11'h020] = 16'h0300; mem[11'h300] = 16'h1111;
    mem[11'h022] = 16'h0301; mem[11'h301] = 16'h5555;
    mem[11'h002] = 16'h0100; mem[11'h100] = 16'h0400; mem[11'h400] = 16'h00FF;
    mem[11'h050] = 16'hDEAD;
    mem[11'h030] = 16'h0031; mem[11'h031] = 16'h0032; mem[11'h032] = 16'h0077;

    test_reset;
    test_direct_read;
    test_ldi;
    test_sti;
    test_rw_conflict;
    test_chain_waits;
    test_clamp;
    test_reset_midop;

    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
